// File: rtl/sweeper_pkg.sv
// Shared types and helpers for the exhaustive input sweeper.
// FSM encoding, Gray conversion and hold-counter sizing.
package sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam int MAX_N_IN = 8;

  function automatic int hold_w(input int hold);
    return $clog2(hold);
  endfunction

  function automatic logic [MAX_N_IN-1:0] to_gray(
    input logic [MAX_N_IN-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/exhaustive_sweeper_if.sv
// Sweep control, stimulus and result bundle.
// master = sweeper side, slave = controller / device side.
interface exhaustive_sweeper_if #(
  parameter int N_IN = 4
);
  logic            start;
  logic            mode;
  logic            dut_f;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic [N_IN:0]   err_count;
  logic [N_IN-1:0] first_err;
  logic            first_err_vld;

  modport master (
    input  start, mode, dut_f,
    output stim, busy, done,
    output err_count, first_err, first_err_vld
  );

  modport slave (
    output start, mode, dut_f,
    input  stim, busy, done,
    input  err_count, first_err, first_err_vld
  );
endinterface

// File: rtl/sweep_checker.sv
// Compares sampled device response against the golden table;
// keeps a saturating error count and the first failing vector.
module sweep_checker #(
  parameter int N_IN = 4,
  parameter logic [2**N_IN-1:0] GOLDEN = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            sample,
  input  logic [N_IN-1:0] stim,
  input  logic            dut_f,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err,
  output logic            first_err_vld
);

  localparam logic [N_IN:0] ERR_MAX = {1'b1, {N_IN{1'b0}}};

  logic exp_f;
  logic miss;

  assign exp_f = GOLDEN[stim];
  assign miss  = sample && (dut_f != exp_f);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else if (clear) begin
      err_count     <= '0;
      first_err     <= '0;
      first_err_vld <= 1'b0;
    end else if (miss) begin
      if (err_count != ERR_MAX)
        err_count <= err_count + 1'b1;
      if (!first_err_vld) begin
        first_err     <= stim;
        first_err_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/exhaustive_sweeper.sv
// Drives every input vector (binary or Gray order) for HOLD
// cycles each and checks the device response against GOLDEN.
module exhaustive_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int HOLD = 10,
  parameter logic [2**N_IN-1:0] GOLDEN = '0
) (
  input  logic                clk,
  input  logic                rst,
  exhaustive_sweeper_if.master bus
);

  localparam int HW = hold_w(HOLD);

  state_e          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            mode_q, mode_d;
  logic            done_q, done_d;

  logic accept;
  logic last_hold;
  logic last_vec;
  logic sample;
  logic [MAX_N_IN-1:0] gray_full;
  logic [N_IN-1:0]     stim;
  logic                gray_unused;

  assign accept    = bus.start && (state_q != RUN);
  assign last_hold = (hold_q == HW'(HOLD - 1));
  assign last_vec  = &idx_q;
  assign sample    = (state_q == RUN) && last_hold;

  assign gray_full   = to_gray(MAX_N_IN'(idx_q));
  assign gray_unused = &{1'b0, gray_full};

  always_comb begin
    stim = '0;
    if (state_q == RUN)
      stim = mode_q ? gray_full[N_IN-1:0] : idx_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    done_d  = done_q;
    unique case (state_q)
      IDLE, FIN: begin
        if (accept) begin
          state_d = RUN;
          idx_d   = '0;
          hold_d  = '0;
          mode_d  = bus.mode;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (last_hold) begin
          hold_d = '0;
          if (last_vec) begin
            state_d = FIN;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stim = stim;
  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;

  sweep_checker #(
    .N_IN   (N_IN),
    .GOLDEN (GOLDEN)
  ) u_chk (
    .clk           (clk),
    .rst           (rst),
    .clear         (accept),
    .sample        (sample),
    .stim          (stim),
    .dut_f         (bus.dut_f),
    .err_count     (bus.err_count),
    .first_err     (bus.first_err),
    .first_err_vld (bus.first_err_vld)
  );

endmodule

// File: tb/tb_exhaustive_sweeper.sv
// Directed bench: three sweepers share one AND-gate device
// model with matching, all-zero and inverted golden tables.
module tb_exhaustive_sweeper;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic mode;
  int   total = 0;
  int   bad   = 0;

  logic [3:0] gseq [16] = '{4'd0, 4'd1, 4'd3, 4'd2,
                            4'd6, 4'd7, 4'd5, 4'd4,
                            4'd12, 4'd13, 4'd15, 4'd14,
                            4'd10, 4'd11, 4'd9, 4'd8};

  always #5 clk = ~clk;

  exhaustive_sweeper_if #(.N_IN(4)) ia ();
  exhaustive_sweeper_if #(.N_IN(4)) ib ();
  exhaustive_sweeper_if #(.N_IN(4)) ic ();

  assign ia.start = start;
  assign ia.mode  = mode;
  assign ia.dut_f = &ia.stim;
  assign ib.start = start;
  assign ib.mode  = mode;
  assign ib.dut_f = &ib.stim;
  assign ic.start = start;
  assign ic.mode  = mode;
  assign ic.dut_f = &ic.stim;

  exhaustive_sweeper #(
    .N_IN(4), .HOLD(10), .GOLDEN(16'h8000)
  ) u_a (.clk(clk), .rst(rst), .bus(ia));

  exhaustive_sweeper #(
    .N_IN(4), .HOLD(10), .GOLDEN(16'h0000)
  ) u_b (.clk(clk), .rst(rst), .bus(ib));

  exhaustive_sweeper #(
    .N_IN(4), .HOLD(10), .GOLDEN(16'h7FFF)
  ) u_c (.clk(clk), .rst(rst), .bus(ic));

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_sweep(input logic m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_sweep(input logic m, input int poke);
    logic [3:0] exp;
    for (int c = 0; c < 160; c++) begin
      exp = m ? gseq[c/10] : 4'(c / 10);
      check("stim", 32'(ia.stim), 32'(exp));
      check("busy_run", 32'(ia.busy), 32'd1);
      check("done_run", 32'(ia.done), 32'd0);
      if (c == poke) begin
        start = 1'b1;
        mode  = ~m;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_fin", 32'(ia.done), 32'd1);
    check("busy_fin", 32'(ia.busy), 32'd0);
    check("stim_fin", 32'(ia.stim), 32'd0);
  endtask

  task automatic end_checks();
    check("a_err", 32'(ia.err_count), 32'd0);
    check("a_vld", 32'(ia.first_err_vld), 32'd0);
    check("b_err", 32'(ib.err_count), 32'd1);
    check("b_first", 32'(ib.first_err), 32'hF);
    check("b_vld", 32'(ib.first_err_vld), 32'd1);
    check("c_err", 32'(ic.err_count), 32'd16);
    check("c_first", 32'(ic.first_err), 32'd0);
    check("c_vld", 32'(ic.first_err_vld), 32'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    #3;
    check("rst_stim", 32'(ia.stim), 32'd0);
    check("rst_busy", 32'(ia.busy), 32'd0);
    check("rst_done", 32'(ia.done), 32'd0);
    check("rst_err", 32'(ic.err_count), 32'd0);
    check("rst_vld", 32'(ic.first_err_vld), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(ia.busy), 32'd0);

    // binary order
    begin_sweep(1'b0);
    run_sweep(1'b0, -1);
    end_checks();

    // Gray order
    begin_sweep(1'b1);
    run_sweep(1'b1, -1);
    end_checks();

    // reset during vector 7
    begin_sweep(1'b0);
    repeat (73) @(negedge clk);
    check("pre_rst_stim", 32'(ia.stim), 32'd7);
    check("pre_rst_err", 32'(ic.err_count), 32'd7);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_stim", 32'(ia.stim), 32'd0);
    check("mid_rst_busy", 32'(ia.busy), 32'd0);
    check("mid_rst_done", 32'(ia.done), 32'd0);
    check("mid_rst_err", 32'(ic.err_count), 32'd0);
    check("mid_rst_first", 32'(ic.first_err), 32'd0);
    check("mid_rst_vld", 32'(ic.first_err_vld), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_done", 32'(ia.done), 32'd0);
    check("post_rst_busy", 32'(ia.busy), 32'd0);
    begin_sweep(1'b0);
    run_sweep(1'b0, -1);
    end_checks();

    // start during RUN is ignored, start in FIN restarts
    begin_sweep(1'b0);
    run_sweep(1'b0, 55);
    end_checks();
    start = 1'b1;
    mode  = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check("re_busy", 32'(ia.busy), 32'd1);
    check("re_done", 32'(ia.done), 32'd0);
    check("re_stim", 32'(ia.stim), 32'd0);
    check("re_err", 32'(ic.err_count), 32'd0);
    check("re_vld", 32'(ic.first_err_vld), 32'd0);
    check("re_b_first", 32'(ib.first_err), 32'd0);
    repeat (10) @(negedge clk);
    check("re_stim1", 32'(ia.stim), 32'd1);
    check("re_err1", 32'(ic.err_count), 32'd1);

    // rst and start together
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rs_busy", 32'(ia.busy), 32'd0);
    check("rs_stim", 32'(ia.stim), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rs_idle", 32'(ia.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exhaustive_sweeper.md
EXHAUSTIVE_SWEEPER -- requirements
Module: exhaustive_sweeper

Interface
REQ-001 SHALL have parameter N_IN, default 4: width of the driven input vector; legal range 1..8.
REQ-002 SHALL have parameter HOLD, default 10: cycles each vector is held; legal range 2..255.
REQ-003 SHALL have parameter GOLDEN, default all-zero, 2**N_IN bits: expected output, where bit k is the expected value for stim==k.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that requests a sweep.
REQ-007 SHALL have port mode, input, 1 bit: 0 = binary order, 1 = Gray order; sampled only when a start is accepted.
REQ-008 SHALL have port stim, output, N_IN bits: vector driven to the device under test.
REQ-009 SHALL have port dut_f, input, 1 bit: response from the device under test.
REQ-010 SHALL have port busy, output, 1 bit: high while a sweep is running.
REQ-011 SHALL have port done, output, 1 bit: high from sweep completion until the next accepted start or rst.
REQ-012 SHALL have port err_count, output, N_IN+1 bits: number of mismatching vectors in the current or last sweep.
REQ-013 SHALL have port first_err, output, N_IN bits: stim value of the first mismatch.
REQ-014 SHALL have port first_err_vld, output, 1 bit: high when first_err holds a captured mismatch.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and FIN; IDLE SHALL also be the reset state.
REQ-016 SHALL accept start only in IDLE or FIN; start in RUN SHALL be ignored with no effect.
REQ-017 On an accepted start, SHALL, on that edge: enter RUN; latch mode; clear the index counter, hold counter, err_count, first_err and first_err_vld; clear done; set busy.
REQ-018 SHALL drive stim with index i in binary order, or with i^(i>>1) in Gray order, where i runs from 0 to 2**N_IN-1.
REQ-019 SHALL drive each stim value for exactly HOLD consecutive cycles; the first vector SHALL appear in the first RUN cycle.
REQ-020 SHALL sample dut_f on the last hold cycle of each vector and compare it against GOLDEN[stim].
REQ-021 On a mismatch, SHALL increment err_count by 1; on the first mismatch of a sweep, SHALL also capture first_err=stim and set first_err_vld=1.
REQ-022 err_count SHALL NOT wrap: its maximum is 2**N_IN, which fits in N_IN+1 bits.
REQ-023 After the last hold cycle of the last vector, SHALL enter FIN with busy=0 and done=1.
REQ-024 A sweep SHALL total exactly 2**N_IN*HOLD RUN cycles.
REQ-025 In IDLE and FIN, stim SHALL hold 0.
REQ-026 A start pulse in FIN SHALL begin a new sweep, following the same rules as from IDLE.

Reset
REQ-027 When rst is asserted, all outputs SHALL be forced immediately to: stim=0, busy=0, done=0, err_count=0, first_err=0, first_err_vld=0; the FSM SHALL go to IDLE.
REQ-028 When rst is asserted mid-sweep, SHALL abort the sweep with no completion indication; after rst is released, the block SHALL require a new start.
REQ-029 When rst and start are high on the same edge, rst SHALL win.

Structure
REQ-030 State encodings SHALL reside in shared package sweeper_pkg.
REQ-031 The Gray conversion SHALL reside in shared package sweeper_pkg.
REQ-032 The hold-counter width SHALL reside in shared package sweeper_pkg, defined as $clog2(HOLD).
REQ-033 SHALL contain one sub-module, sweep_checker, holding the compare logic, err_count and the first-error capture; the FSM and counters SHALL be in the top level.

Verification
REQ-034 Scenario 1: N_IN=4, HOLD=10, GOLDEN matching the DUT, mode=0, pulse start -> stim steps 0..15 every 10 cycles; done rises after exactly 160 RUN cycles; err_count=0; first_err_vld=0.
REQ-035 Scenario 2: as scenario 1 with mode=1 -> stim sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8; err_count=0.
REQ-036 Scenario 3: GOLDEN=16'h0000 against a DUT whose output is f=x&y&w&z -> err_count=1; first_err=4'hF; first_err_vld=1.
REQ-037 Scenario 4: GOLDEN inverted relative to the DUT -> err_count=16, with no wrap; first_err=0.
REQ-038 Scenario 5: assert rst during vector 7 -> all outputs 0 immediately; no done; start a new sweep after release -> full correct sweep.
REQ-039 Scenario 6: pulse start during RUN -> the sweep continues unchanged; then pulse start in FIN -> counters cleared and a new sweep begins on the next cycle.
